// File: rtl/dmr_retry_arbiter_if.sv
// Requester, downstream, retry and completion signals of dmr_retry_arbiter.
// The slave modport is the arbiter's view; master is the surrounding pipeline.
interface dmr_retry_arbiter_if #(
   parameter type DataType = logic [7:0],
   parameter int  NumReq   = 4,
   parameter int  IDSize   = 4
);
   localparam int SrcW = (NumReq > 1) ? $clog2(NumReq) : 1;

   DataType             req_data_i [NumReq];
   logic [NumReq-1:0]   req_valid_i;
   logic [NumReq-1:0]   req_ready_o;
   DataType             data_o;
   logic [IDSize-1:0]   id_o;
   logic                valid_o;
   logic                ready_i;
   logic                retry_valid_i;
   logic [IDSize-1:0]   retry_id_i;
   logic                retry_ready_o;
   logic                done_valid_i;
   logic [IDSize-1:0]   done_id_i;
   logic [SrcW-1:0]     done_src_o;
   logic [IDSize:0]     inflight_o;
   logic                id_error_o;

   modport slave (
      input  req_data_i, req_valid_i, ready_i, retry_valid_i, retry_id_i,
             done_valid_i, done_id_i,
      output req_ready_o, data_o, id_o, valid_o, retry_ready_o, done_src_o,
             inflight_o, id_error_o
   );

   modport master (
      output req_data_i, req_valid_i, ready_i, retry_valid_i, retry_id_i,
             done_valid_i, done_id_i,
      input  req_ready_o, data_o, id_o, valid_o, retry_ready_o, done_src_o,
             inflight_o, id_error_o
   );
endinterface

// File: rtl/dmr_retry_arbiter.sv
// Round-robin arbiter in front of a time-DMR pipeline: owns the retry-ID pool,
// keeps every in-flight payload so a retry can be replayed under its original ID.
module dmr_retry_arbiter #(
   parameter type DataType = logic [7:0],
   parameter int  NumReq   = 4,
   parameter int  IDSize   = 4
) (
   input logic                clk_i,
   input logic                rst_ni,
   dmr_retry_arbiter_if.slave bus
);
   localparam int Depth = 2 ** IDSize;
   localparam int SrcW  = (NumReq > 1) ? $clog2(NumReq) : 1;

   typedef logic [IDSize-1:0] id_t;
   typedef logic [SrcW-1:0]   src_t;
   typedef logic [IDSize:0]   cnt_t;

   typedef enum logic [1:0] {
      LOAD_NONE,
      LOAD_PENDING,
      LOAD_RETRY,
      LOAD_NEW
   } load_e;

   // ID table
   logic [Depth-1:0] in_use_q;
   DataType          payload_q [Depth];
   src_t             src_q     [Depth];

   // Output slot, retry buffer, arbitration and status state
   logic    valid_q;
   DataType data_q;
   id_t     id_q;
   logic    retry_pending_q;
   id_t     retry_id_q;
   src_t    rr_ptr_q;
   cnt_t    inflight_q;
   logic    id_error_q;

   logic    slot_load, retry_acc, retry_same, retry_live, retry_bad;
   logic    done_hit, done_bad, pending_live, pending_d, alloc;
   logic    free_found, grant_found;
   id_t     free_id;
   src_t    grant_idx;
   int      rr_idx;
   load_e   load_sel;
   DataType slot_data_d;
   id_t     slot_id_d;
   logic [NumReq-1:0] req_ready;

   assign slot_load  = ~valid_q | bus.ready_i;
   assign retry_acc  = bus.retry_valid_i & ~retry_pending_q;
   assign retry_same = bus.done_valid_i & (bus.retry_id_i == bus.done_id_i);
   assign retry_live = retry_acc & ~retry_same & in_use_q[bus.retry_id_i];
   assign retry_bad  = retry_acc & ~retry_same & ~in_use_q[bus.retry_id_i];
   assign done_hit   = bus.done_valid_i & in_use_q[bus.done_id_i];
   assign done_bad   = bus.done_valid_i & ~in_use_q[bus.done_id_i];
   // A buffered retry whose ID completes before it is replayed is dropped.
   assign pending_live = retry_pending_q & ~(done_hit & (bus.done_id_i == retry_id_q));
   assign pending_d    = (retry_pending_q ? pending_live : retry_live) & ~slot_load;
   assign alloc        = (load_sel == LOAD_NEW);

   // Lowest free ID, judged on the table as it stood at the start of the cycle.
   always_comb begin
      // NOTE: every always_comb output gets a default first, so no path leaves
      // it unassigned and no latch is inferred.
      free_found = 1'b0;
      free_id    = '0;
      for (int i = 0; i < Depth; i++) begin
         if (!in_use_q[id_t'(i)] && !free_found) begin
            free_found = 1'b1;
            free_id    = id_t'(i);
         end
      end
   end

   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      rr_idx      = 0;
      for (int k = 0; k < NumReq; k++) begin
         rr_idx = (int'(rr_ptr_q) + k) % NumReq;
         if (bus.req_valid_i[src_t'(rr_idx)] && !grant_found) begin
            grant_found = 1'b1;
            grant_idx   = src_t'(rr_idx);
         end
      end
   end

   // Slot source priority: buffered retry, then incoming retry, then new request.
   always_comb begin
      load_sel = LOAD_NONE;
      if (slot_load) begin
         if (pending_live)                                load_sel = LOAD_PENDING;
         else if (retry_live)                             load_sel = LOAD_RETRY;
         else if (free_found && grant_found && rst_ni)    load_sel = LOAD_NEW;
      end
   end

   always_comb begin
      slot_data_d = data_q;
      slot_id_d   = id_q;
      unique case (load_sel)
         LOAD_PENDING: begin
            slot_data_d = payload_q[retry_id_q];
            slot_id_d   = retry_id_q;
         end
         LOAD_RETRY: begin
            slot_data_d = payload_q[bus.retry_id_i];
            slot_id_d   = bus.retry_id_i;
         end
         LOAD_NEW: begin
            slot_data_d = bus.req_data_i[grant_idx];
            slot_id_d   = free_id;
         end
         default: ;
      endcase
   end

   always_comb begin
      req_ready = '0;
      if (alloc) req_ready[grant_idx] = 1'b1;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (!rst_ni) begin
         valid_q         <= 1'b0;
         data_q          <= '0;
         id_q            <= '0;
         retry_pending_q <= 1'b0;
         retry_id_q      <= '0;
         rr_ptr_q        <= '0;
         inflight_q      <= '0;
         id_error_q      <= 1'b0;
         in_use_q        <= '0;
      end else begin
         if (slot_load) begin
            valid_q <= (load_sel != LOAD_NONE);
            data_q  <= slot_data_d;
            id_q    <= slot_id_d;
         end
         retry_pending_q <= pending_d;
         if (!retry_pending_q && retry_live) retry_id_q <= bus.retry_id_i;
         id_error_q <= retry_bad | done_bad;
         if (alloc) begin
            in_use_q[free_id] <= 1'b1;
            rr_ptr_q <= (int'(grant_idx) == NumReq - 1) ? '0 : grant_idx + src_t'(1);
         end
         if (done_hit) in_use_q[bus.done_id_i] <= 1'b0;
         unique case ({alloc, done_hit})
            2'b10:   inflight_q <= inflight_q + cnt_t'(1);
            2'b01:   inflight_q <= inflight_q - cnt_t'(1);
            default: ;
         endcase
      end
   end

   // NOTE: payload and source storage is left out of reset; in_use_q alone
   // says which entries are meaningful.
   always_ff @(posedge clk_i) begin
      if (alloc) begin
         payload_q[free_id] <= bus.req_data_i[grant_idx];
         src_q[free_id]     <= grant_idx;
      end
   end

   assign bus.req_ready_o   = req_ready;
   assign bus.data_o        = data_q;
   assign bus.id_o          = id_q;
   assign bus.valid_o       = valid_q;
   assign bus.retry_ready_o = ~retry_pending_q;
   assign bus.done_src_o    = src_q[bus.done_id_i];
   assign bus.inflight_o    = inflight_q;
   assign bus.id_error_o    = id_error_q;
endmodule

// File: tb/tb_dmr_retry_arbiter.sv
// Self-checking bench for dmr_retry_arbiter: directed scenarios followed by
// randomized traffic, all compared against a cycle-level reference model.
module tb_dmr_retry_arbiter;
   localparam int NumReq = 4;
   localparam int IDSize = 4;
   localparam int Depth  = 16;

   logic clk_i  = 1'b0;
   logic rst_ni = 1'b0;
   always #5 clk_i = ~clk_i;

   dmr_retry_arbiter_if #(.DataType(logic [7:0]), .NumReq(NumReq), .IDSize(IDSize)) bus ();

   dmr_retry_arbiter #(.DataType(logic [7:0]), .NumReq(NumReq), .IDSize(IDSize)) dut (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .bus    (bus)
   );

   int n_cmp = 0;
   int n_err = 0;

   // Reference model state
   bit         m_used [Depth];
   logic [7:0] m_pay  [Depth];
   int         m_src  [Depth];
   bit         m_valid, m_pend, m_err;
   logic [7:0] m_data;
   int         m_id, m_pend_id, m_rr, m_infl;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < Depth; i++) m_used[i] = 1'b0;
      m_valid = 0; m_pend = 0; m_err = 0; m_data = '0;
      m_id = 0; m_pend_id = 0; m_rr = 0; m_infl = 0;
   endfunction

   function automatic int lowest_free();
      for (int i = 0; i < Depth; i++) if (!m_used[i]) return i;
      return -1;
   endfunction

   function automatic int rr_pick();
      for (int k = 0; k < NumReq; k++) begin
         int idx = (m_rr + k) % NumReq;
         if (bus.req_valid_i[idx]) return idx;
      end
      return -1;
   endfunction

   task automatic idle_inputs();
      bus.req_valid_i   = '0;
      for (int r = 0; r < NumReq; r++) bus.req_data_i[r] = '0;
      bus.ready_i       = 1'b0;
      bus.retry_valid_i = 1'b0;
      bus.retry_id_i    = '0;
      bus.done_valid_i  = 1'b0;
      bus.done_id_i     = '0;
   endtask

   // Evaluate one cycle of the reference model against the currently driven inputs.
   task automatic model_cycle();
      bit slot_load, retry_acc, same, done_ok, replay_now, pend_alive, loaded;
      int fid, g, grant, did, rid;
      did        = int'(bus.done_id_i);
      rid        = int'(bus.retry_id_i);
      slot_load  = !m_valid || bus.ready_i;
      retry_acc  = bus.retry_valid_i && !m_pend;
      same       = bus.done_valid_i && (rid == did);
      done_ok    = bus.done_valid_i && m_used[did];
      replay_now = retry_acc && !same && m_used[rid];
      pend_alive = m_pend && !(done_ok && did == m_pend_id);
      fid = lowest_free();
      g   = rr_pick();
      grant  = -1;
      loaded = 0;

      check("retry_ready", bus.retry_ready_o, {31'd0, !m_pend});
      if (done_ok) check("done_src", bus.done_src_o, m_src[did]);

      m_err = (bus.done_valid_i && !m_used[did]) || (retry_acc && !same && !m_used[rid]);

      if (slot_load && pend_alive) begin
         m_valid = 1; m_data = m_pay[m_pend_id]; m_id = m_pend_id; loaded = 1;
      end else if (slot_load && replay_now) begin
         m_valid = 1; m_data = m_pay[rid]; m_id = rid; loaded = 1;
      end else if (slot_load && fid >= 0 && g >= 0) begin
         grant = g;
      end else if (slot_load) begin
         m_valid = 0;
      end

      check("req_ready", bus.req_ready_o, (grant >= 0) ? (32'd1 << grant) : 32'd0);

      if (m_pend) m_pend = pend_alive && !slot_load;
      else if (replay_now && !loaded) begin
         m_pend = 1; m_pend_id = rid;
      end

      if (grant >= 0) begin
         m_used[fid] = 1; m_pay[fid] = bus.req_data_i[grant]; m_src[fid] = grant;
         m_rr = (grant + 1) % NumReq;
         m_valid = 1; m_data = bus.req_data_i[grant]; m_id = fid;
         m_infl++;
      end
      if (done_ok) begin
         m_used[did] = 0;
         m_infl--;
      end
   endtask

   task automatic step();
      @(negedge clk_i);
      model_cycle();
      @(posedge clk_i);
      #1;
      check("valid_o",    bus.valid_o,    {31'd0, m_valid});
      check("data_o",     bus.data_o,     {24'd0, m_data});
      check("id_o",       bus.id_o,       m_id);
      check("inflight_o", bus.inflight_o, m_infl);
      check("id_error_o", bus.id_error_o, {31'd0, m_err});
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_ni = 1'b0;
      model_reset();
      @(posedge clk_i);
      @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not reach its summary");
      $fatal(1, "watchdog expired");
   end

   initial begin
      do_reset();
      check("rst_valid",       bus.valid_o,       0);
      check("rst_data",        bus.data_o,        0);
      check("rst_id",          bus.id_o,          0);
      check("rst_req_ready",   bus.req_ready_o,   0);
      check("rst_retry_ready", bus.retry_ready_o, 1);
      check("rst_inflight",    bus.inflight_o,    0);
      check("rst_id_error",    bus.id_error_o,    0);

      // 1: single requester, then completion
      bus.req_valid_i = 4'b0100; bus.req_data_i[2] = 8'hA5; bus.ready_i = 1'b1;
      step();
      check("t1_valid", bus.valid_o, 1);
      check("t1_data",  bus.data_o,  8'hA5);
      check("t1_id",    bus.id_o,    0);
      bus.req_valid_i = '0; bus.done_valid_i = 1'b1; bus.done_id_i = 4'd0;
      #1 check("t1_done_src", bus.done_src_o, 2);
      step();
      check("t1_inflight", bus.inflight_o, 0);
      bus.done_valid_i = 1'b0;

      // 2: round-robin over all requesters
      do_reset();
      bus.req_valid_i = 4'b1111; bus.ready_i = 1'b1;
      for (int r = 0; r < NumReq; r++) bus.req_data_i[r] = 8'h10 + 8'(r);
      for (int n = 0; n < 5; n++) begin
         step();
         check("t2_id",  bus.id_o,   n);
         check("t2_src", bus.data_o, 8'h10 + 8'(n % NumReq));
      end

      // 3: pool full, retry still replays, done frees exactly one ID
      do_reset();
      bus.req_valid_i = 4'b1111; bus.ready_i = 1'b1;
      for (int n = 0; n < Depth; n++) begin
         for (int r = 0; r < NumReq; r++) bus.req_data_i[r] = 8'h30 + 8'(n);
         step();
      end
      check("t3_inflight", bus.inflight_o, 16);
      check("t3_full_rdy", bus.req_ready_o, 0);
      bus.retry_valid_i = 1'b1; bus.retry_id_i = 4'd5;
      step();
      check("t3_replay_id",   bus.id_o,   5);
      check("t3_replay_data", bus.data_o, 8'h35);
      bus.retry_valid_i = 1'b0; bus.done_valid_i = 1'b1; bus.done_id_i = 4'd7;
      step();
      check("t3_freed", bus.inflight_o, 15);
      bus.done_valid_i = 1'b0;
      step();
      check("t3_reuse_id", bus.id_o, 7);
      check("t3_refull",   bus.inflight_o, 16);

      // 4: retry beats a waiting request; output holds under backpressure
      do_reset();
      bus.req_valid_i = 4'b0010; bus.ready_i = 1'b1;
      for (int n = 0; n < 4; n++) begin
         bus.req_data_i[1] = 8'h40 + 8'(n);
         step();
      end
      bus.req_valid_i = 4'b0001; bus.req_data_i[0] = 8'hC0;
      bus.retry_valid_i = 1'b1; bus.retry_id_i = 4'd3;
      step();
      check("t4_replay_id",   bus.id_o,   3);
      check("t4_replay_data", bus.data_o, 8'h43);
      bus.retry_valid_i = 1'b0; bus.ready_i = 1'b0;
      for (int n = 0; n < 5; n++) begin
         step();
         check("t4_hold_id",   bus.id_o,   3);
         check("t4_hold_data", bus.data_o, 8'h43);
      end
      bus.ready_i = 1'b1;
      step();
      check("t4_next_id",   bus.id_o,   4);
      check("t4_next_data", bus.data_o, 8'hC0);

      // 5: retry and done for an unused ID
      bus.req_valid_i = '0;
      bus.retry_valid_i = 1'b1; bus.retry_id_i = 4'd9;
      step();
      check("t5_retry_err", bus.id_error_o, 1);
      check("t5_retry_inf", bus.inflight_o, 5);
      bus.retry_valid_i = 1'b0;
      step();
      check("t5_err_clear", bus.id_error_o, 0);
      check("t5_no_output", bus.valid_o,    0);
      bus.done_valid_i = 1'b1; bus.done_id_i = 4'd9;
      step();
      check("t5_done_err", bus.id_error_o, 1);
      check("t5_done_inf", bus.inflight_o, 5);
      bus.done_valid_i = 1'b0;
      step();
      check("t5_err_clear2", bus.id_error_o, 0);

      // 6: reset mid-stream
      do_reset();
      bus.req_valid_i = 4'b1111; bus.ready_i = 1'b1;
      for (int n = 0; n < 6; n++) step();
      check("t6_inflight_pre", bus.inflight_o, 6);
      #2 rst_ni = 1'b0;
      #1;
      check("t6_valid",     bus.valid_o,     0);
      check("t6_inflight",  bus.inflight_o,  0);
      check("t6_req_ready", bus.req_ready_o, 0);
      model_reset();
      @(posedge clk_i);
      #1 rst_ni = 1'b1;
      bus.req_valid_i = 4'b1000; bus.req_data_i[3] = 8'h77;
      step();
      check("t6_first_id", bus.id_o,   0);
      check("t6_data",     bus.data_o, 8'h77);

      // Randomized traffic against the model
      do_reset();
      for (int c = 0; c < 600; c++) begin
         int used_q[$];
         bus.req_valid_i = 4'($urandom);
         for (int r = 0; r < NumReq; r++) bus.req_data_i[r] = 8'($urandom);
         bus.ready_i       = ($urandom_range(0, 3) != 0);
         bus.retry_valid_i = ($urandom_range(0, 6) == 0);
         bus.retry_id_i    = 4'($urandom);
         for (int i = 0; i < Depth; i++) if (m_used[i]) used_q.push_back(i);
         bus.done_valid_i  = ($urandom_range(0, 3) == 0);
         if (used_q.size() > 0 && $urandom_range(0, 9) < 8)
            bus.done_id_i = 4'(used_q[$urandom_range(0, used_q.size() - 1)]);
         else
            bus.done_id_i = 4'($urandom);
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
